// File: rtl/seq_gen_serial_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit word MSB-first, repeated rpt
// times with optional idle gap bits between frames, flagging each frame's last bit.
module seq_gen_serial_tx #(
  parameter int unsigned     WIDTH    = 4,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(4'b1011),
  parameter int unsigned     CNT_W    = 4,
  parameter int unsigned     GAP      = 0,
  parameter logic            IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_din,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] rpt,
  input  logic             abort,
  output logic             x,
  output logic             valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] word, word_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0] bit_idx, idx_nxt;
  logic [CNT_W-1:0] frames, frames_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             x_nxt, valid_nxt, last_nxt, busy_nxt, done_nxt;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // Next-state and next-output logic; `load` starts a frame from its MSB.
  always_comb begin
    state_nxt  = state;
    word_nxt   = word;
    shreg_nxt  = shreg;
    idx_nxt    = bit_idx;
    frames_nxt = frames;
    gap_nxt    = gap_cnt;
    x_nxt      = IDLE_BIT;
    valid_nxt  = 1'b0;
    last_nxt   = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    load       = 1'b0;
    load_word  = word;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          load_word  = use_din ? din : PATTERN;
          word_nxt   = load_word;
          frames_nxt = (rpt == '0) ? CNT_W'(1) : rpt;
          load       = 1'b1;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (bit_idx != '0) begin
          shreg_nxt = shreg << 1;
          idx_nxt   = bit_idx - IDX_W'(1);
          x_nxt     = shreg_nxt[WIDTH-1];
          valid_nxt = 1'b1;
          last_nxt  = (idx_nxt == '0);
          busy_nxt  = 1'b1;
        end else if (frames > CNT_W'(1)) begin
          frames_nxt = frames - CNT_W'(1);
          if (GAP > 0) begin
            state_nxt = S_GAP;
            gap_nxt   = GAP_W'(GAP - 1);
            busy_nxt  = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else begin
          state_nxt  = S_IDLE;
          frames_nxt = '0;
          done_nxt   = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (gap_cnt != '0) begin
          gap_nxt  = gap_cnt - GAP_W'(1);
          busy_nxt = 1'b1;
        end else begin
          load = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (load) begin
      state_nxt = S_SEND;
      shreg_nxt = load_word;
      idx_nxt   = IDX_W'(WIDTH - 1);
      x_nxt     = load_word[WIDTH-1];
      valid_nxt = 1'b1;
      last_nxt  = (WIDTH == 1);
      busy_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      word     <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      frames   <= '0;
      gap_cnt  <= '0;
      x        <= IDLE_BIT;
      valid    <= 1'b0;
      last_bit <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      word     <= word_nxt;
      shreg    <= shreg_nxt;
      bit_idx  <= idx_nxt;
      frames   <= frames_nxt;
      gap_cnt  <= gap_nxt;
      x        <= x_nxt;
      valid    <= valid_nxt;
      last_bit <= last_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_gen_serial_tx.sv
// Bench for seq_gen_serial_tx: a back-to-back instance and a GAP=2 instance
// (idle level 1) share stimulus and are checked every cycle against a frame-queue model.
module tb_seq_gen_serial_tx;

  logic       clk = 1'b0;
  logic       rst, start, use_din, abort;
  logic [3:0] din, rpt;
  logic       x0, v0, l0, b0, d0;
  logic       x2, v2, l2, b2, d2;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;
  bit det_en = 1'b0;
  logic [3:0] hist = '0;

  always #5 clk = ~clk;

  seq_gen_serial_tx #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(4), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .use_din(use_din), .din(din), .rpt(rpt),
    .abort(abort), .x(x0), .valid(v0), .last_bit(l0), .busy(b0), .done(d0));

  seq_gen_serial_tx #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(4), .GAP(2), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .use_din(use_din), .din(din), .rpt(rpt),
    .abort(abort), .x(x2), .valid(v2), .last_bit(l2), .busy(b2), .done(d2));

  wire [4:0] o0 = {x0, v0, l0, b0, d0};
  wire [4:0] o2 = {x2, v2, l2, b2, d2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: on an accepted start, the whole transfer is laid out as a list of
  // per-cycle output tuples {x,valid,last_bit,busy,done}, then replayed.
  logic [4:0] q [2][$];
  logic [4:0] emod [2];
  int         gapn [2] = '{0, 2};
  logic       ib   [2] = '{1'b0, 1'b1};

  always @(posedge clk) begin : model
    int n;
    logic [3:0] w;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        q[k].delete();
        emod[k] = {ib[k], 4'b0000};
      end else if (emod[k][1] && abort) begin
        q[k].delete();
        emod[k] = {ib[k], 4'b0000};
      end else if (q[k].size() > 0) begin
        emod[k] = q[k].pop_front();
      end else if (start && !abort) begin
        n = (rpt == 4'd0) ? 1 : int'(rpt);
        w = use_din ? din : 4'b1011;
        for (int f = 0; f < n; f++) begin
          for (int b = 3; b >= 0; b--)
            q[k].push_back({w[b], 1'b1, (b == 0), 1'b1, 1'b0});
          if (f < n - 1)
            for (int g = 0; g < gapn[k]; g++) q[k].push_back({ib[k], 4'b0010});
        end
        q[k].push_back({ib[k], 4'b0001});
        emod[k] = q[k].pop_front();
      end else begin
        emod[k] = {ib[k], 4'b0000};
      end
    end
  end

  // Per-cycle compare, plus a 1011 overlapping-detector check while enabled.
  always @(posedge clk) begin
    #1;
    hist = {hist[2:0], x0};
    if (chk_en) begin
      chk("dut0_outputs", 32'(o0), 32'(emod[0]));
      chk("dut2_outputs", 32'(o2), 32'(emod[1]));
      if (det_en) chk("detector_y_vs_last_bit", 32'(hist == 4'b1011), 32'(l0));
    end
  end

  task automatic capture(input int n, input bit sel,
                         output logic [15:0] cx, output logic [15:0] cv, output logic [15:0] cl,
                         output logic [15:0] cb, output logic [15:0] cd);
    cx = '0; cv = '0; cl = '0; cb = '0; cd = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      cx = {cx[14:0], sel ? x2 : x0};
      cv = {cv[14:0], sel ? v2 : v0};
      cl = {cl[14:0], sel ? l2 : l0};
      cb = {cb[14:0], sel ? b2 : b0};
      cd = {cd[14:0], sel ? d2 : d0};
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (d0) break;
      @(negedge clk);
    end
    if (i == 100) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [15:0] cx, cv, cl, cb, cd;
  int          seen;

  initial begin
    rst = 1'b1; start = 1'b0; use_din = 1'b0; abort = 1'b0; din = '0; rpt = '0;
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outputs_dut0", 32'(o0), 32'h00);
    chk("reset_outputs_dut2", 32'(o2), 32'h10);
    rst = 1'b0;

    // 1: single default frame
    rpt = 4'd1;
    pulse_start();
    capture(5, 1'b0, cx, cv, cl, cb, cd);
    chk("t1_x", 32'(cx[4:0]), 32'(5'b10110));
    chk("t1_valid", 32'(cv[4:0]), 32'(5'b11110));
    chk("t1_last", 32'(cl[4:0]), 32'(5'b00010));
    chk("t1_busy", 32'(cb[4:0]), 32'(5'b11110));
    chk("t1_done", 32'(cd[4:0]), 32'(5'b00001));

    // 2: three back-to-back frames with overlapping detector check
    repeat (5) @(negedge clk);
    det_en = 1'b1; rpt = 4'd3;
    pulse_start();
    capture(13, 1'b0, cx, cv, cl, cb, cd);
    chk("t2_x", 32'(cx[12:0]), 32'(13'b1011101110110));
    chk("t2_valid", 32'(cv[12:0]), 32'(13'b1111111111110));
    chk("t2_last", 32'(cl[12:0]), 32'(13'b0001000100010));
    chk("t2_done", 32'(cd[12:0]), 32'(13'b0000000000001));
    det_en = 1'b0;

    // 3: din frames with two gap bits on the GAP=2 instance
    repeat (3) @(negedge clk);
    rpt = 4'd2; use_din = 1'b1; din = 4'b0110;
    pulse_start();
    capture(11, 1'b1, cx, cv, cl, cb, cd);
    chk("t3_x", 32'(cx[10:0]), 32'(11'b01101101101));
    chk("t3_valid", 32'(cv[10:0]), 32'(11'b11110011110));
    chk("t3_busy", 32'(cb[10:0]), 32'(11'b11111111110));
    chk("t3_done", 32'(cd[10:0]), 32'(11'b00000000001));
    use_din = 1'b0;

    // 4: rpt=0, ignored restart mid-transfer, restart in the done cycle
    repeat (3) @(negedge clk);
    rpt = 4'd0;
    pulse_start();
    cx = '0; cv = '0; cd = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      cx = {cx[14:0], x0}; cv = {cv[14:0], v0}; cd = {cd[14:0], d0};
      start = (i == 1) || (i == 4);
      use_din = (i == 1);
      din = (i == 1) ? 4'b0000 : din;
    end
    chk("t4_x", 32'(cx[4:0]), 32'(5'b10110));
    chk("t4_valid", 32'(cv[4:0]), 32'(5'b11110));
    chk("t4_done", 32'(cd[4:0]), 32'(5'b00001));
    @(negedge clk); start = 1'b0; use_din = 1'b0;
    chk("t4_restart", 32'({x0, v0, b0}), 32'(3'b111));
    wait_done("t4");

    // 5: abort at the second bit, then abort+start together in idle
    repeat (3) @(negedge clk);
    rpt = 4'd2;
    pulse_start();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t5_after_abort", 32'({v0, b0, d0, l0}), 32'(4'b0000));
    seen = 0;
    repeat (10) begin @(negedge clk); if (d0 || b0) seen++; end
    chk("t5_no_done", 32'(seen), 32'd0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    chk("t5_abort_beats_start", 32'({v0, b0}), 32'(2'b00));

    // 6: reset mid-frame, then full frame afterwards
    repeat (3) @(negedge clk);
    rpt = 4'd1;
    pulse_start();
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_reset_dut0", 32'(o0), 32'h00);
    chk("t6_reset_dut2", 32'(o2), 32'h10);
    pulse_start();
    capture(5, 1'b0, cx, cv, cl, cb, cd);
    chk("t6_x", 32'(cx[4:0]), 32'(5'b10110));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(3) == 0);
      use_din = 1'($urandom_range(1));
      din     = 4'($urandom);
      rpt     = ($urandom_range(7) == 0) ? 4'($urandom) : 4'($urandom_range(3));
      abort   = ($urandom_range(39) == 0);
      rst     = ($urandom_range(399) == 0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (120) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
